alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for one shared 4-bit ALU
// Optional illegal-opcode bypass: define ALU_ARB_OPCHK_EN.
module alu_arbiter #(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_op,
  input  logic [1:0] req_cin,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [3:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_of,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_res,
  output logic       rsp_cout,
  output logic       rsp_of,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] lat_a, lat_b, lat_op;
  logic       lat_cin, lat_id;
  logic       last_grant;
  logic [3:0] wait_cnt;
  logic [3:0] rsp_res_q;
  logic       rsp_cout_q, rsp_of_q;
  logic       grant, accept, exec_done, op_bad;
  logic [3:0] sel_a, sel_b, sel_op;
  logic       sel_cin;

  // last_grant names the requester that won most recently; the other one wins a tie
  always_comb begin
    if (req_valid == 2'b11) grant = ~last_grant;
    else                    grant = req_valid[1];
  end

  assign sel_a   = grant ? req_a[7:4]  : req_a[3:0];
  assign sel_b   = grant ? req_b[7:4]  : req_b[3:0];
  assign sel_op  = grant ? req_op[7:4] : req_op[3:0];
  assign sel_cin = grant ? req_cin[1]  : req_cin[0];

`ifdef ALU_ARB_OPCHK_EN
  logic rsp_err_q;
  assign op_bad  = (sel_op == 4'd0) || (sel_op > 4'd8);
  assign rsp_err = rsp_err_q;
`else
  assign op_bad  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    exec_done = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          accept    = 1'b1;
          req_ready = grant ? 2'b10 : 2'b01;
          state_nxt = op_bad ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (wait_cnt == WAIT_LAST) begin
          exec_done = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU sees the latched operands only while executing, quiet zeros otherwise
  assign alu_a     = (state == EXEC) ? lat_a   : 4'd0;
  assign alu_b     = (state == EXEC) ? lat_b   : 4'd0;
  assign alu_op    = (state == EXEC) ? lat_op  : 4'd0;
  assign alu_cin   = (state == EXEC) ? lat_cin : 1'b0;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = lat_id;
  assign rsp_res   = rsp_res_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_of    = rsp_of_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_a      <= 4'd0;
      lat_b      <= 4'd0;
      lat_op     <= 4'd0;
      lat_cin    <= 1'b0;
      lat_id     <= 1'b0;
      wait_cnt   <= 4'd0;
      rsp_res_q  <= 4'd0;
      rsp_cout_q <= 1'b0;
      rsp_of_q   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_a      <= sel_a;
        lat_b      <= sel_b;
        lat_op     <= sel_op;
        lat_cin    <= sel_cin;
        lat_id     <= grant;
        last_grant <= grant;
        wait_cnt   <= 4'd0;
`ifdef ALU_ARB_OPCHK_EN
        if (op_bad) begin
          rsp_res_q  <= 4'd0;
          rsp_cout_q <= 1'b0;
          rsp_of_q   <= 1'b0;
          rsp_err_q  <= 1'b1;
        end
`endif
      end
      if (state == EXEC) wait_cnt <= wait_cnt + 4'd1;
      if (exec_done) begin
        rsp_res_q  <= alu_res;
        rsp_cout_q <= alu_cout;
        rsp_of_q   <= alu_of;
`ifdef ALU_ARB_OPCHK_EN
        rsp_err_q  <= 1'b0;
`endif
      end
    end
  end

endmodule
